// File: rtl/pc_sequencer_if.sv
// Decoder-to-sequencer bundle: control inputs towards the sequencer, PC and RAS status back.
`timescale 1ns/1ps
`ifndef DATASIZE
`define DATASIZE 16
`endif

interface pc_sequencer_if #(
    parameter int unsigned datawidth = `DATASIZE,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

    logic                 en;
    logic [2:0]           op;
    logic                 cond;
    logic [datawidth-1:0] target;
    logic [datawidth-1:0] pc;
    logic [CntW-1:0]      ras_count;
    logic                 ras_full;
    logic                 ras_empty;
    logic                 ras_ovf;
    logic                 ras_unf;

    modport master (
        output en, op, cond, target,
        input  pc, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
    );

    modport slave (
        input  en, op, cond, target,
        output pc, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered PC sequencer: increment, relative branch, absolute jump and call/return
// through a circular return-address stack.
`timescale 1ns/1ps
`ifndef DATASIZE
`define DATASIZE 16
`endif

module pc_sequencer #(
    parameter int unsigned          datawidth    = `DATASIZE,
    parameter int unsigned          STEP         = 1,
    parameter int unsigned          RAS_DEPTH    = 4,
    parameter logic [datawidth-1:0] RESET_VECTOR = '0
) (
    input logic          clk,
    input logic          rst,
    pc_sequencer_if.slave bus
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [datawidth-1:0] StepVal = datawidth'(STEP);
    localparam logic [CntW-1:0]      FullCnt = CntW'(RAS_DEPTH);
    localparam logic [PtrW-1:0]      LastPtr = PtrW'(RAS_DEPTH - 1);

    localparam logic [2:0] OpInc    = 3'b000;
    localparam logic [2:0] OpBranch = 3'b001;
    localparam logic [2:0] OpJump   = 3'b010;
    localparam logic [2:0] OpCall   = 3'b011;
    localparam logic [2:0] OpRet    = 3'b100;

    logic [datawidth-1:0] pc_q, pc_d;
    logic [PtrW-1:0]      top_q, top_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 push;

    logic [datawidth-1:0] ras_q [RAS_DEPTH];

    logic [datawidth-1:0] seq_pc;
    logic [PtrW-1:0]      top_inc;
    logic [PtrW-1:0]      top_dec;

    assign seq_pc  = pc_q + StepVal;
    // Explicit wrap keeps the pointer legal for non-power-of-two depths.
    assign top_inc = (top_q == LastPtr) ? '0 : top_q + PtrW'(1);
    assign top_dec = (top_q == '0) ? LastPtr : top_q - PtrW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents need no reset; the count alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_q[top_d] <= seq_pc;
        end
    end

    always_comb begin
        pc_d  = pc_q;
        top_d = top_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        push  = 1'b0;
        if (bus.en) begin
            case (bus.op)
                OpInc: begin
                    pc_d = seq_pc;
                end
                OpBranch: begin
                    pc_d = bus.cond ? pc_q + bus.target : seq_pc;
                end
                OpJump: begin
                    pc_d = bus.target;
                end
                OpCall: begin
                    push  = 1'b1;
                    pc_d  = bus.target;
                    top_d = top_inc;
                    // When full the push lands on the oldest entry and the count stays put.
                    if (cnt_q == FullCnt) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                OpRet: begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_q[top_q];
                        top_d = top_dec;
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        pc_d  = seq_pc;
                        unf_d = 1'b1;
                    end
                end
                default: begin
                    pc_d = seq_pc;
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.ras_count = cnt_q;
    assign bus.ras_full  = (cnt_q == FullCnt);
    assign bus.ras_empty = (cnt_q == '0);
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter sequencer for the custom RISC core: the successor to the combinational `increment` datapath. It holds the current PC and, every enabled cycle, advances it by a parametrised step, takes a relative branch, takes an absolute jump, or performs a call/return through an internal return-address stack (RAS) of parametrised depth. It sits between the decoder/branch unit and the instruction-fetch address port.

## Interface
- `datawidth`, default `` `datasize ``: width of PC, target and offset.
- `STEP`, default 1: increment applied for sequential flow and for call return addresses.
- `RAS_DEPTH`, default 4: number of RAS entries, ≥ 2.
- `RESET_VECTOR`, default 0: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; 0 = stall, all state held.
- `op`  in  3  000 INC, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET; 101–111 behave as INC.
- `cond`  in  1  branch condition, used only for BRANCH.
- `target`  in  datawidth  signed offset for BRANCH, absolute address for JUMP/CALL.
- `pc`  out  datawidth  current PC (registered).
- `ras_count`  out  clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH.
- `ras_full`  out  1  ras_count == RAS_DEPTH.
- `ras_empty`  out  1  ras_count == 0.
- `ras_ovf`  out  1  one-cycle pulse: CALL executed while full.
- `ras_unf`  out  1  one-cycle pulse: RET executed while empty.

## Operation
- All arithmetic is modulo 2^datawidth; no saturation, no carry output.
- INC: pc ← pc + STEP.
- BRANCH: cond=1 → pc ← pc + target (target two's-complement signed); cond=0 → pc ← pc + STEP.
- JUMP: pc ← target.
- CALL: push (pc + STEP) onto RAS; pc ← target. When full, the push overwrites the oldest entry (circular), ras_count stays RAS_DEPTH, ras_ovf pulses.
- RET: RAS not empty → pc ← top entry, pop. Empty → pc ← pc + STEP, ras_count stays 0, ras_unf pulses.
- RAS is a circular buffer with a top pointer and a count; pointers wrap modulo RAS_DEPTH.
- en=0: pc, RAS contents, pointer, count held; op/cond/target ignored; ras_ovf/ras_unf driven 0.
- ras_full, ras_empty are combinational decodes of the registered ras_count.

## Timing
- Latency 1: op sampled at rising edge N appears on `pc` after edge N.
- No handshake; decoder presents op/cond/target stable around each enabled edge.
- ras_ovf/ras_unf are registered, asserted exactly in the cycle after the offending edge, cleared next edge unless repeated.
- Back-to-back CALL/RET every cycle supported; RET immediately after CALL returns that CALL's pc+STEP.
- Reset (asynchronous, any time, including mid-sequence): pc = RESET_VECTOR, ras_count = 0, ras_empty = 1, ras_full = 0, ras_ovf = ras_unf = 0; RAS contents are don't-care. First update occurs at the first rising edge after rst deasserts.

## Test plan
Bench parameters: datawidth=16, STEP=1, RAS_DEPTH=4, RESET_VECTOR=16'h0100.
- Reset, then 3 cycles INC with en=1 → pc 0x0100, 0x0101, 0x0102, 0x0103; ras_empty=1.
- pc=0xFFFF, INC → 0x0000. Then BRANCH with cond=1, target=0xFFFE → 0xFFFE. BRANCH with cond=0 → 0xFFFF.
- From pc=0x0200: CALL 0x1000, CALL 0x2000, RET, RET → pc 0x1000, 0x2000, 0x1001, 0x0201; ras_count 1,2,1,0.
- Five CALLs to 0x0A00..0x0A04 starting at pc=0x0100 → 5th cycle ras_ovf=1, ras_count=4; four RETs return 0x0A04, 0x0A03, 0x0A02, 0x0A01 (entry 0x0101 lost); fifth RET → pc+1, ras_unf=1.
- en=0 for 3 cycles with op=JUMP target 0x5555 → pc unchanged, no flags. Assert rst mid-cycle with ras_count=2 → pc=0x0100 and ras_count=0 immediately, without waiting for a clock edge.
